dpr_as: RTL and testbench

//  - Single-clock 1024x16 block-RAM macro with a registered address, a read-data register and a

---
 rtl/dpr_as.sv | 78 +++++++
 tb/tb_dpr_as.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dpr_as.sv
// 1024x16 single-clock RAM: registered address, read-data register, gated output register with parity (PARITY_ODD_EN selects odd parity).
// Latency: addr sampled at edge N, mem access at N+1, dout/parity_out valid after N+2; read-first on same-address write+read.
// No backpressure: every enable acts on its edge; only 1'b1 enables are active, and writes are blocked while rst is low.
module dpr_as #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              blk_sel,
    input  logic              addr_en,
    input  logic              dout_en,
    input  logic              rst,
    output logic              parity_out,
    output logic [DATA_W-1:0] dout,
    input  logic              clk
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef PARITY_ODD_EN
    localparam logic PARITY_RST = 1'b1;
    function automatic logic parity(input logic [DATA_W-1:0] x);
        return ~^x;
    endfunction
`else
    localparam logic PARITY_RST = 1'b0;
    function automatic logic parity(input logic [DATA_W-1:0] x);
        return ^x;
    endfunction
`endif

    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] rd_data;
    logic              do_wr;
    logic              do_rd;

    // An X enable evaluates as non-true in the if() below, so it never writes.
    assign do_wr = (blk_sel == 1'b1) && (wr_en == 1'b1);
    assign do_rd = (blk_sel == 1'b1) && (rd_en == 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_reg <= '0;
        end else if (addr_en == 1'b1) begin
            addr_reg <= addr;
        end
    end

    // Array is not reset; rst sampled low on the edge suppresses the write.
    always_ff @(posedge clk) begin
        if ((rst == 1'b1) && do_wr) begin
            mem1[addr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (do_rd) begin
            rd_data <= mem1[addr_reg];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout       <= '0;
            parity_out <= PARITY_RST;
        end else if (dout_en == 1'b1) begin
            dout       <= rd_data;
            parity_out <= parity(rd_data);
        end
    end

endmodule

// File: tb/tb_dpr_as.sv
// Randomised bench for dpr_as against a queue-free array reference model of the RAM pipeline.
module tb_dpr_as;

    logic [15:0] din;
    logic [9:0]  addr;
    logic        wr_en, rd_en, blk_sel, addr_en, dout_en, rst;
    logic        parity_out;
    logic [15:0] dout;
    logic        clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_mem [1024];
    logic [9:0]  m_addr;
    logic [15:0] m_rd;
    logic [15:0] m_dout;

    dpr_as dut (
        .din(din), .addr(addr), .wr_en(wr_en), .rd_en(rd_en), .blk_sel(blk_sel),
        .addr_en(addr_en), .dout_en(dout_en), .rst(rst), .parity_out(parity_out),
        .dout(dout), .clk(clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [15:0] x);
`ifdef PARITY_ODD_EN
        return ~^x;
`else
        return ^x;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model on the edge, then compare outputs.
    task automatic step(input logic [15:0] d, input logic [9:0] a, input logic we, input logic re,
                        input logic bs, input logic ae, input logic de, input string tag);
        logic [9:0]  old_a;
        logic [15:0] old_r;
        din = d; addr = a; wr_en = we; rd_en = re; blk_sel = bs; addr_en = ae; dout_en = de;
        @(posedge clk);
        old_a = m_addr;
        old_r = m_rd;
        if (bs && re) m_rd = m_mem[old_a];
        if (bs && we) m_mem[old_a] = d;
        if (ae) m_addr = a;
        if (de) m_dout = old_r;
        #1;
        check({tag, "_dout"}, {16'h0, dout}, {16'h0, m_dout});
        check({tag, "_par"}, {31'h0, parity_out}, {31'h0, exp_par(m_dout)});
    endtask

    // Full access to one location: load address, then write or read, then present on dout.
    task automatic wr_word(input logic [9:0] a, input logic [15:0] d);
        step(16'h0, a, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "wa");
        step(d, 10'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "wd");
    endtask

    task automatic rd_word(input logic [9:0] a);
        step(16'h0, a, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "ra");
        step(16'h0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rr");
        step(16'h0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "ro");
    endtask

    initial begin
        logic [15:0] held;
        m_addr = '0; m_rd = '0; m_dout = '0;

        // Reset must clear outputs without a clock edge
        din = 16'($urandom); addr = 10'($urandom); wr_en = 1'b1; rd_en = 1'b1;
        blk_sel = 1'b1; addr_en = 1'b1; dout_en = 1'b1; rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_dout", {16'h0, dout}, 32'h0);
        check("rst_par", {31'h0, parity_out}, {31'h0, exp_par(16'h0)});
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill every location through the port; writes trail the address by one cycle
        for (int i = 0; i <= 1024; i++)
            step(16'($urandom), 10'(i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "fill");

        // Write/readback at the top address, all enables high for the read
        wr_word(10'h3FF, 16'hA5A5);
        step(16'h0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "t2a");
        step(16'h0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "t2b");
        step(16'h0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "t2c");
        check("t2_dout", {16'h0, dout}, 32'h0000A5A5);
`ifdef PARITY_ODD_EN
        check("t2_par", {31'h0, parity_out}, 32'h1);
`else
        check("t2_par", {31'h0, parity_out}, 32'h0);
`endif

        // Single-bit word parity
        wr_word(10'h007, 16'h0001);
        rd_word(10'h007);
        check("t3_dout", {16'h0, dout}, 32'h00000001);
`ifdef PARITY_ODD_EN
        check("t3_par", {31'h0, parity_out}, 32'h0);
`else
        check("t3_par", {31'h0, parity_out}, 32'h1);
`endif

        // blk_sel low blocks the write
        step(16'h0, 10'h007, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "g1a");
        step(16'hFFFF, 10'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "g1b");
        rd_word(10'h007);
        check("t4_blk", {16'h0, dout}, 32'h00000001);

        // addr_en low ignores the new address
        wr_word(10'h100, 16'h5555);
        step(16'h0, 10'h007, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "g2a");
        step(16'h0, 10'h100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "g2b");
        step(16'h0, 10'h100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "g2c");
        check("t4_addr", {16'h0, dout}, 32'h00000001);

        // dout_en low holds dout while rd_data changes
        held = dout;
        step(16'h0, 10'h100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "g3a");
        step(16'h0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "g3b");
        step(16'h0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "g3c");
        check("t4_hold", {16'h0, dout}, {16'h0, held});

        // Read-first on same-address write+read
        wr_word(10'h005, 16'h1234);
        step(16'h0, 10'h005, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "rf1");
        step(16'hBEEF, 10'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "rf2");
        step(16'h0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "rf3");
        check("t5_old", {16'h0, dout}, 32'h00001234);
        rd_word(10'h005);
        check("t5_new", {16'h0, dout}, 32'h0000BEEF);

        // Reset mid-operation: regs clear at once, write on the reset edge is suppressed
        wr_word(10'h000, 16'h0F0F);
        din = 16'hDEAD; addr = 10'h0; wr_en = 1'b1; rd_en = 1'b1; blk_sel = 1'b1;
        addr_en = 1'b0; dout_en = 1'b1;
        rst = 1'b0;
        #1;
        m_addr = '0; m_rd = '0; m_dout = '0;
        check("rst2_dout", {16'h0, dout}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(16'h0, 10'h3FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rst2a");
        step(16'h0, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "rst2b");
        check("rst2_mem", {16'h0, dout}, 32'h00000F0F);

        // Random soak: write-heavy phase then read-heavy phase
        for (int i = 0; i < 10000; i++)
            step(16'($urandom), 10'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), "soakw");
        for (int i = 0; i < 10000; i++)
            step(16'($urandom), 10'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), "soakr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
